// File: rtl/insn_sequencer.sv
// insn_sequencer: fetch/decode sequencer driving the instruction side of the
// WF8 bus controller. Fetches one byte at PC, decodes opcode [7:3] into a
// one-hot insn_en plus reg_num [2:0], waits for insn_done, pulses pc_inc.
// Optional EXEC watchdog is built when the macro SEQ_TIMEOUT_EN is defined;
// without it, timeout is tied to 0 and EXEC waits indefinitely.
//
// state | meaning
// IDLE  | one settling cycle after reset
// FETCH | RAM read strobe at PC
// LOAD  | fetched byte arrives, decoded at the closing edge
// EXEC  | insn_en/reg_num held until insn_done
// INC   | one-cycle pc_inc, retired count bumps
// TRAP  | illegal opcode or watchdog expiry; only reset leaves
module insn_sequencer #(
  parameter int INSN_COUNT     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_pc,
  output logic                  o_fetch_en,
  output logic [7:0]            o_fetch_addr,
  input  logic [7:0]            i_fetch_data,
  output logic [INSN_COUNT-1:0] o_insn_en,
  output logic [2:0]            o_reg_num,
  input  logic                  i_insn_done,
  output logic                  o_pc_inc,
  output logic                  o_illegal,
  output logic                  o_timeout,
  output logic [15:0]           o_retired
);

  if (INSN_COUNT < 1 || INSN_COUNT > 32) begin : g_bad_insn_count
    $error("INSN_COUNT must be in 1..32 (5-bit opcode)");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 4-bit watchdog counter");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_INC   = 3'd4,
    S_TRAP  = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_fetch_en, w_fetch_en_nxt;
  logic [INSN_COUNT-1:0] r_insn_en, w_insn_en_nxt;
  logic [2:0]            r_reg_num, w_reg_num_nxt;
  logic                  r_pc_inc, w_pc_inc_nxt;
  logic                  r_illegal, w_illegal_nxt;
  logic [15:0]           r_retired, w_retired_nxt;

  logic [4:0]            w_opcode;
  logic                  w_legal;
  logic [INSN_COUNT-1:0] w_decoded;

`ifdef SEQ_TIMEOUT_EN
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_timeout, w_timeout_nxt;
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign w_opcode  = i_fetch_data[7:3];
  assign w_legal   = (32'(w_opcode) < INSN_COUNT);
  assign w_decoded = INSN_COUNT'(1) << w_opcode;

  // Next-state and next-output decode; outputs are registered with the state.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_en_nxt = 1'b0;
    w_insn_en_nxt  = r_insn_en;
    w_reg_num_nxt  = r_reg_num;
    w_pc_inc_nxt   = 1'b0;
    w_illegal_nxt  = r_illegal;
    w_retired_nxt  = r_retired;
`ifdef SEQ_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
    w_timeout_nxt  = r_timeout;
`endif
    case (r_state)
      S_IDLE: begin
        w_state_nxt    = S_FETCH;
        w_fetch_en_nxt = 1'b1;
      end
      S_FETCH: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_legal) begin
          w_insn_en_nxt = w_decoded;
          w_reg_num_nxt = i_fetch_data[2:0];
          w_state_nxt   = S_EXEC;
`ifdef SEQ_TIMEOUT_EN
          w_cnt_nxt     = 4'd0;
`endif
        end else begin
          w_insn_en_nxt = '0;
          w_illegal_nxt = 1'b1;
          w_state_nxt   = S_TRAP;
        end
      end
      S_EXEC: begin
        // insn_done beats a same-cycle watchdog expiry.
        if (i_insn_done) begin
          w_insn_en_nxt = '0;
          w_pc_inc_nxt  = 1'b1;
          w_state_nxt   = S_INC;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (r_cnt + 4'd1 == 4'(TIMEOUT_CYCLES)) begin
          w_insn_en_nxt = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_TRAP;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
`endif
      end
      S_INC: begin
        w_retired_nxt  = r_retired + 16'd1;
        w_fetch_en_nxt = 1'b1;
        w_state_nxt    = S_FETCH;
      end
      S_TRAP: begin
        w_state_nxt = S_TRAP;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_fetch_en <= 1'b0;
      r_insn_en  <= '0;
      r_reg_num  <= 3'd0;
      r_pc_inc   <= 1'b0;
      r_illegal  <= 1'b0;
      r_retired  <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_en <= w_fetch_en_nxt;
      r_insn_en  <= w_insn_en_nxt;
      r_reg_num  <= w_reg_num_nxt;
      r_pc_inc   <= w_pc_inc_nxt;
      r_illegal  <= w_illegal_nxt;
      r_retired  <= w_retired_nxt;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // EXEC watchdog counter and sticky timeout flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= 4'd0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
`endif

  assign o_fetch_en   = r_fetch_en;
  assign o_fetch_addr = (r_state == S_FETCH) ? i_pc : 8'd0;
  assign o_insn_en    = r_insn_en;
  assign o_reg_num    = r_reg_num;
  assign o_pc_inc     = r_pc_inc;
  assign o_illegal    = r_illegal;
  assign o_retired    = r_retired;

endmodule
